// File: rtl/phy_rx_lanes.sv
`default_nettype none
// ============================================================================
// Module   : phy_rx_lanes
// Purpose  : Multi-lane serial receive PHY.
//            - Deserialises LANES serial lines (MSB first).
//            - Word-aligns each lane on the COM character.
//            - Unstripes the aligned data symbols round-robin into one stream.
//            - Demultiplexes that stream round-robin onto CHANNELS registered
//              output ports, each with a single-cycle valid strobe.
//
// Ports    : clk_8f       in   bit clock, one serial bit per lane per edge
//            reset_L      in   asynchronous active-low reset
//            serial_in    in   [LANES]           bit l = lane l
//            data_out     out  [CHANNELS*WIDTH]  channel c at [c*WIDTH +: WIDTH]
//            valid_out    out  [CHANNELS]        one-cycle strobe per channel
//            lane_locked  out  [LANES]           lane l in LOCKED state
//            all_locked   out  1                 registered AND of lane_locked
//            overflow     out  [LANES]           sticky, lane symbol overwritten
//
// Options  : RX_LOSS_DET_EN - when defined, a locked lane that sees MAX_GAP
//            consecutive non-COM symbols falls back to SEARCH. When undefined,
//            lanes leave LOCKED only on reset and MAX_GAP is unused.
//
// Revision : 1.0 - initial release
// ============================================================================
module phy_rx_lanes #(
    parameter int               LANES      = 2,
    parameter int               CHANNELS   = 2,
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM        = 8'hBC,
    parameter int               LOCK_COUNT = 4,
    parameter int               MAX_GAP    = 16
) (
    input  logic                      clk_8f,
    input  logic                      reset_L,
    input  logic [LANES-1:0]          serial_in,
    output logic [CHANNELS*WIDTH-1:0] data_out,
    output logic [CHANNELS-1:0]       valid_out,
    output logic [LANES-1:0]          lane_locked,
    output logic                      all_locked,
    output logic [LANES-1:0]          overflow
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(LOCK_COUNT + 1);
    localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LOCK_CNT_C = CNT_W'(LOCK_COUNT);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(LANES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(CHANNELS - 1);

`ifdef RX_LOSS_DET_EN
    localparam int               GAP_W    = $clog2(MAX_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP - 1);
`else
    // Gap detection is compiled out; keep the parameter referenced.
    logic [31:0] unused_max_gap;
    assign unused_max_gap = MAX_GAP;
`endif

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_LOCKING = 2'd1,
        ST_LOCKED  = 2'd2
    } lane_state_e;

    // ------------------------------------------------------------------
    // Shared signals between the lanes and the unstriper
    // ------------------------------------------------------------------
    logic                   all_locked_q;
    logic [LANES-1:0]       lane_locked_w;
    logic [LANES-1:0]       pending_w;
    logic [LANES-1:0]       consume_w;
    logic [LANES*WIDTH-1:0] hold_w;

    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic                   take_w;

    // ------------------------------------------------------------------
    // Per-lane deserialiser, aligner and holding register
    // ------------------------------------------------------------------
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lane_state_e      state_q, state_d;
        logic [WIDTH-2:0] sr_q;
        logic [WIDTH-1:0] next_sym;
        logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
        logic [CNT_W-1:0] com_cnt_q, com_cnt_d;
        logic [WIDTH-1:0] hold_q, hold_d;
        logic             pending_q, pending_d;
        logic             ovf_q, ovf_d;
        logic             locked_q;
        logic             boundary;
        logic             is_com;
        logic             capture;
        logic             lost;
`ifdef RX_LOSS_DET_EN
        logic [GAP_W-1:0] gap_q, gap_d;
`endif

        // Symbol completed by the bit arriving this edge.
        assign next_sym = {sr_q, serial_in[l]};
        assign is_com   = (next_sym == COM);
        assign boundary = (bit_cnt_q == LAST_BIT);

        // Alignment state machine: next-state logic.
        always_comb begin
            state_d   = state_q;
            bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
            com_cnt_d = com_cnt_q;
            capture   = 1'b0;
            lost      = 1'b0;
`ifdef RX_LOSS_DET_EN
            gap_d     = '0;
`endif
            unique case (state_q)
                ST_SEARCH: begin
                    // Bit-sliding: any edge may complete a COM.
                    if (is_com) begin
                        bit_cnt_d = '0;
                        com_cnt_d = CNT_W'(1);
                        state_d   = (LOCK_COUNT == 1) ? ST_LOCKED : ST_LOCKING;
                    end
                end
                ST_LOCKING: begin
                    if (boundary) begin
                        if (is_com) begin
                            com_cnt_d = com_cnt_q + 1'b1;
                            if ((com_cnt_q + 1'b1) == LOCK_CNT_C) begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            state_d   = ST_SEARCH;
                            com_cnt_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
`ifdef RX_LOSS_DET_EN
                    gap_d = gap_q;
                    if (boundary) begin
                        if (is_com) begin
                            gap_d = '0;
                        end else if (gap_q == GAP_LAST) begin
                            // The symbol that exhausts the gap is discarded.
                            state_d   = ST_SEARCH;
                            com_cnt_d = '0;
                            lost      = 1'b1;
                            gap_d     = '0;
                        end else begin
                            capture = 1'b1;
                            gap_d   = gap_q + 1'b1;
                        end
                    end
`else
                    // COM symbols are idle fill and are dropped here.
                    if (boundary && !is_com) begin
                        capture = 1'b1;
                    end
`endif
                end
                default: begin
                    state_d   = ST_SEARCH;
                    com_cnt_d = '0;
                end
            endcase
        end

        // Holding register. A capture that lands while the previous symbol
        // is still waiting (and not leaving this cycle) is an overflow; a
        // capture coinciding with consumption simply refills the slot.
        always_comb begin
            hold_d    = hold_q;
            pending_d = pending_q;
            ovf_d     = ovf_q;
            if (consume_w[l]) begin
                pending_d = 1'b0;
            end
            if (capture) begin
                hold_d    = next_sym;
                pending_d = 1'b1;
                if (pending_q && !consume_w[l]) begin
                    ovf_d = 1'b1;
                end
            end
            if (lost || !all_locked_q) begin
                pending_d = 1'b0;
            end
        end

        always_ff @(posedge clk_8f or negedge reset_L) begin
            if (!reset_L) begin
                state_q   <= ST_SEARCH;
                sr_q      <= '0;
                bit_cnt_q <= '0;
                com_cnt_q <= '0;
                hold_q    <= '0;
                pending_q <= 1'b0;
                ovf_q     <= 1'b0;
                locked_q  <= 1'b0;
`ifdef RX_LOSS_DET_EN
                gap_q     <= '0;
`endif
            end else begin
                state_q   <= state_d;
                sr_q      <= next_sym[WIDTH-2:0];
                bit_cnt_q <= bit_cnt_d;
                com_cnt_q <= com_cnt_d;
                hold_q    <= hold_d;
                pending_q <= pending_d;
                ovf_q     <= ovf_d;
                locked_q  <= (state_d == ST_LOCKED);
`ifdef RX_LOSS_DET_EN
                gap_q     <= gap_d;
`endif
            end
        end

        assign lane_locked_w[l]            = locked_q;
        assign pending_w[l]                = pending_q;
        assign hold_w[l*WIDTH +: WIDTH]    = hold_q;
        assign overflow[l]                 = ovf_q;
        // Strict round-robin: only the lane under the pointer may drain.
        assign consume_w[l] = all_locked_q && pending_q && (ptr_q == PTR_W'(l));
    end

    // ------------------------------------------------------------------
    // Unstriper
    // ------------------------------------------------------------------
    logic             ustr_valid_q;
    logic [WIDTH-1:0] ustr_data_q;

    assign take_w = |consume_w;

    always_comb begin
        ptr_d = ptr_q;
        if (!all_locked_q) begin
            ptr_d = '0;
        end else if (take_w) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            all_locked_q <= 1'b0;
            ptr_q        <= '0;
            ustr_valid_q <= 1'b0;
            ustr_data_q  <= '0;
        end else begin
            all_locked_q <= &lane_locked_w;
            ptr_q        <= ptr_d;
            ustr_valid_q <= take_w;
            if (take_w) begin
                ustr_data_q <= hold_w[ptr_q*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Demultiplexer
    // ------------------------------------------------------------------
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [CHANNELS*WIDTH-1:0] data_q, data_d;
    logic [CHANNELS-1:0]       valid_q, valid_d;

    always_comb begin
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = '0;
        if (ustr_valid_q) begin
            data_d[sel_q*WIDTH +: WIDTH] = ustr_data_q;
            valid_d[sel_q]               = 1'b1;
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        end
        // Channel rotation restarts whenever the link is not fully locked.
        if (!all_locked_q) begin
            sel_d = '0;
        end
    end

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign lane_locked = lane_locked_w;
    assign all_locked  = all_locked_q;

endmodule
`default_nettype wire

// File: tb/tb_phy_rx_lanes.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_rx_lanes
// Purpose  : Self-checking bench for phy_rx_lanes (LANES=2, CHANNELS=2).
//            Lane traffic is described as per-lane symbol slots plus a bit
//            delay; expected output is the data symbols taken slot by slot,
//            lane by lane, dealt round-robin to the channels.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phy_rx_lanes;

    localparam int               LANES    = 2;
    localparam int               CHANNELS = 2;
    localparam int               WIDTH    = 8;
    localparam int               MAXS     = 32;
    localparam logic [WIDTH-1:0] COM      = 8'hBC;

    logic                      clk_8f    = 1'b0;
    logic                      reset_L   = 1'b1;
    logic [LANES-1:0]          serial_in = '0;
    wire  [CHANNELS*WIDTH-1:0] data_out;
    wire  [CHANNELS-1:0]       valid_out;
    wire  [LANES-1:0]          lane_locked;
    wire                       all_locked;
    wire  [LANES-1:0]          overflow;

    phy_rx_lanes #(
        .LANES      (LANES),
        .CHANNELS   (CHANNELS),
        .WIDTH      (WIDTH),
        .COM        (COM),
        .LOCK_COUNT (4),
        .MAX_GAP    (16)
    ) dut (
        .clk_8f      (clk_8f),
        .reset_L     (reset_L),
        .serial_in   (serial_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .lane_locked (lane_locked),
        .all_locked  (all_locked),
        .overflow    (overflow)
    );

    always #5 clk_8f = ~clk_8f;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0]    syms [LANES][MAXS];
    int                  dly  [LANES];
    int                  t_cur    = 0;
    int                  p0       = 0;
    int                  pcount   = 0;
    int                  first_pc = -1;
    int                  out_idx  = 0;
    logic [WIDTH-1:0]    exp_q [$];
    logic [CHANNELS-1:0] prev_valid = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk_8f) pcount++;

    // Serial bit of lane l at bit time t; slots beyond the table are COM.
    function automatic logic lane_bit(input int l, input int t);
        int rel;
        int k;
        int b;
        logic [WIDTH-1:0] s;
        if (t < dly[l]) return 1'b0;
        rel = t - dly[l];
        k   = rel / WIDTH;
        b   = rel % WIDTH;
        s   = (k < MAXS) ? syms[l][k] : COM;
        return s[WIDTH-1-b];
    endfunction

    function automatic logic [WIDTH-1:0] rand_data();
        logic [WIDTH-1:0] s;
        s = WIDTH'($urandom_range(0, 255));
        while (s == COM) s = WIDTH'($urandom_range(0, 255));
        return s;
    endfunction

    task automatic clear_scenario();
        for (int l = 0; l < LANES; l++) begin
            dly[l] = 0;
            for (int k = 0; k < MAXS; k++) syms[l][k] = COM;
        end
        exp_q.delete();
        out_idx  = 0;
        first_pc = -1;
        t_cur    = 0;
    endtask

    task automatic do_reset();
        serial_in = '0;
        @(negedge clk_8f);
        reset_L = 1'b0;
        repeat (2) @(negedge clk_8f);
        reset_L = 1'b1;
    endtask

    task automatic drive_until(input int tend);
        while (t_cur < tend) begin
            @(negedge clk_8f);
            if (t_cur == 0) p0 = pcount;
            for (int l = 0; l < LANES; l++) serial_in[l] = lane_bit(l, t_cur);
            t_cur++;
        end
    endtask

    // Observe state just after the edge that sampled the last driven bit.
    task automatic settle();
        @(posedge clk_8f);
        #1;
    endtask

    task automatic finish_scenario(input int tend);
        drive_until(tend);
        check_eq("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Output monitor: each strobe is matched to the next expected symbol.
    always @(negedge clk_8f) begin
        if (reset_L && valid_out != '0) begin
            check_eq("onehot", 64'($countones(valid_out)), 64'd1);
            check_eq("pulse_len", 64'(valid_out & prev_valid), 64'd0);
            for (int c = 0; c < CHANNELS; c++) begin
                if (valid_out[c]) begin
                    check_eq("exp_avail", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        check_eq("out_chan", 64'(c), 64'(out_idx % CHANNELS));
                        check_eq("out_data", 64'(data_out[c*WIDTH +: WIDTH]), 64'(exp_q.pop_front()));
                        out_idx++;
                    end
                end
            end
            if (first_pc < 0) first_pc = pcount;
        end
        prev_valid = valid_out;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Initial reset
        #2 reset_L = 1'b0;
        repeat (3) @(negedge clk_8f);
        check_eq("rst_data",   64'(data_out),    64'd0);
        check_eq("rst_valid",  64'(valid_out),   64'd0);
        check_eq("rst_locked", 64'(lane_locked), 64'd0);
        check_eq("rst_all",    64'(all_locked),  64'd0);
        check_eq("rst_ovf",    64'(overflow),    64'd0);
        reset_L = 1'b1;

        // Aligned lanes, two data symbols each
        do_reset();
        clear_scenario();
        syms[0][4] = 8'h11; syms[0][5] = 8'h33;
        syms[1][4] = 8'h22; syms[1][5] = 8'h44;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        drive_until(32);
        settle();
        check_eq("t2_locked", 64'(lane_locked), 64'd3);
        finish_scenario(72);
        check_eq("t2_latency", 64'(first_pc), 64'(p0 + 39 + 3));
        check_eq("t2_ovf", 64'(overflow), 64'd0);

        // Lane 1 delayed three bits
        do_reset();
        clear_scenario();
        dly[1] = 3;
        syms[0][4] = 8'h11; syms[0][5] = 8'h33;
        syms[1][4] = 8'h22; syms[1][5] = 8'h44;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        finish_scenario(80);
        check_eq("t3_ovf", 64'(overflow), 64'd0);
        check_eq("t3_locked", 64'(lane_locked), 64'd3);

        // Broken lock sequence on lane 0, then relock
        do_reset();
        clear_scenario();
        syms[0][3] = 8'h55;
        syms[0][8] = 8'h66;
        syms[1][8] = 8'h77;
        exp_q.push_back(8'h66); exp_q.push_back(8'h77);
        drive_until(24);
        settle();
        check_eq("t4_locking", 64'(lane_locked), 64'd0);
        drive_until(32);
        settle();
        check_eq("t4_search", 64'(lane_locked), 64'd2);
        check_eq("t4_all", 64'(all_locked), 64'd0);
        drive_until(64);
        settle();
        check_eq("t4_relock", 64'(lane_locked), 64'd3);
        finish_scenario(88);

        // Lane 0 overruns while the pointer waits on lane 1
        do_reset();
        clear_scenario();
        syms[0][4] = 8'hA1; syms[0][5] = 8'hA2; syms[0][6] = 8'hA3;
        syms[1][8] = 8'hB1;
        exp_q.push_back(8'hA1); exp_q.push_back(8'hB1); exp_q.push_back(8'hA3);
        drive_until(48);
        settle();
        check_eq("t5_no_ovf_yet", 64'(overflow), 64'd0);
        drive_until(56);
        settle();
        check_eq("t5_ovf", 64'(overflow), 64'd1);
        finish_scenario(88);
        check_eq("t5_ovf_sticky", 64'(overflow), 64'd1);

        // Asynchronous reset between edges
        @(posedge clk_8f);
        #2 reset_L = 1'b0;
        #1;
        check_eq("ar_data",   64'(data_out),    64'd0);
        check_eq("ar_valid",  64'(valid_out),   64'd0);
        check_eq("ar_locked", 64'(lane_locked), 64'd0);
        check_eq("ar_all",    64'(all_locked),  64'd0);
        check_eq("ar_ovf",    64'(overflow),    64'd0);
        @(negedge clk_8f);
        reset_L = 1'b1;
        settle();
        check_eq("ar_post_locked", 64'(lane_locked), 64'd0);

        // Long run of data on lane 0
        do_reset();
        clear_scenario();
        for (int k = 4; k < 20; k++) syms[0][k] = WIDTH'(k - 3);
        exp_q.push_back(8'h01);
        drive_until(152);
        settle();
        check_eq("t6_locked_15", 64'(lane_locked[0]), 64'd1);
        drive_until(160);
        settle();
`ifdef RX_LOSS_DET_EN
        check_eq("t6_locked_16", 64'(lane_locked[0]), 64'd0);
`else
        check_eq("t6_locked_16", 64'(lane_locked[0]), 64'd1);
`endif
        finish_scenario(184);
        check_eq("t6_ovf", 64'(overflow[0]), 64'd1);

        // Randomised traffic with lane skew
        for (int it = 0; it < 8; it++) begin
            do_reset();
            clear_scenario();
            dly[0] = $urandom_range(0, 3);
            dly[1] = $urandom_range(0, 6);
            for (int k = 5; k < 21; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    for (int l = 0; l < LANES; l++) begin
                        syms[l][k] = rand_data();
                        exp_q.push_back(syms[l][k]);
                    end
                end
            end
            finish_scenario(192);
            check_eq("rnd_ovf", 64'(overflow), 64'd0);
            check_eq("rnd_locked", 64'(lane_locked), 64'd3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
